// File: rtl/mem_pkg.sv
// Shared types and defaults for the instruction/data memory request arbiter.
package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {INSTR, DATA} owner_t;

    // Round-robin pick: a tie goes to whichever side did not win last time.
    function automatic owner_t pick_owner(input logic i_pend, input logic d_pend, input owner_t last);
        owner_t winner;
        if (i_pend && d_pend) begin
            winner = (last == INSTR) ? DATA : INSTR;
        end else if (d_pend) begin
            winner = DATA;
        end else begin
            winner = INSTR;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting on the RAM.
// Clearing loads 1 so the first waiting cycle already reads as cycle 1.
// The count saturates once it reaches the limit.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == CNT_W'(TIMEOUT));

    // Next count: clear wins, otherwise step until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_W'(1);
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// One access at a time; each completion gives a one-cycle ready pulse with registered load data.
module mem_request_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ren,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_load,
    output logic              i_ready,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_store,
    output logic [DATA_W-1:0] dmem_load,
    output logic              d_ready,
    output logic              bus_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_busy
);

    arb_state_t        state_q, state_d;
    owner_t            last_grant_q, last_grant_d;
    owner_t            req_owner_q, req_owner_d;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_store_q, req_store_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] imem_load_q, imem_load_d;
    logic [DATA_W-1:0] dmem_load_q, dmem_load_d;

    logic   d_pend;
    logic   expired;
    logic   finish;
    owner_t grant_owner;

    assign d_pend = dmem_ren | dmem_wen;

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ACCESS),
        .enable (state_q == ACCESS),
        .expired(expired)
    );

    assign ram_addr  = req_addr_q;
    assign ram_store = req_store_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign bus_err   = bus_err_q;
    assign imem_load = imem_load_q;
    assign dmem_load = dmem_load_q;

    // Arbitration, request latching and access sequencing; all outputs are computed one cycle ahead.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_owner_d  = req_owner_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_store_d  = req_store_q;
        ram_ren_d    = ram_ren_q;
        ram_wen_d    = ram_wen_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        bus_err_d    = 1'b0;
        imem_load_d  = imem_load_q;
        dmem_load_d  = dmem_load_q;
        finish       = 1'b0;
        grant_owner  = pick_owner(imem_ren, d_pend, last_grant_q);

        case (state_q)
            IDLE: begin
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
                if (imem_ren || d_pend) begin
                    req_owner_d  = grant_owner;
                    last_grant_d = grant_owner;
                    if (grant_owner == DATA) begin
                        req_addr_d  = dmem_addr;
                        req_store_d = dmem_store;
                        req_write_d = dmem_wen;
                    end else begin
                        req_addr_d  = imem_addr;
                        req_store_d = '0;
                        req_write_d = 1'b0;
                    end
                    ram_wen_d = req_write_d;
                    ram_ren_d = !req_write_d;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (!ram_busy) begin
                    if (!req_write_q) begin
                        if (req_owner_q == DATA) begin
                            dmem_load_d = ram_load;
                        end else begin
                            imem_load_d = ram_load;
                        end
                    end
                    finish = 1'b1;
                end else if (expired) begin
                    bus_err_d = 1'b1;
                    finish    = 1'b1;
                end
                if (finish) begin
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    i_ready_d = (req_owner_q == INSTR);
                    d_ready_d = (req_owner_q == DATA);
                    state_d   = RESP;
                end
            end
            RESP: begin
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, request and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= INSTR;
            req_owner_q  <= INSTR;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_store_q  <= '0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            imem_load_q  <= '0;
            dmem_load_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_owner_q  <= req_owner_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_store_q  <= req_store_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            bus_err_q    <= bus_err_d;
            imem_load_q  <= imem_load_d;
            dmem_load_q  <= dmem_load_d;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: vector table plus hand sequences for ties and reset.
module tb_mem_request_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_ren;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_load;
    logic          i_ready;
    logic          dmem_ren;
    logic          dmem_wen;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_store;
    logic [DW-1:0] dmem_load;
    logic          d_ready;
    logic          bus_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_store;
    logic          ram_ren;
    logic          ram_wen;
    logic [DW-1:0] ram_load;
    logic          ram_busy;

    always #5 clk = ~clk;

    mem_request_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_ren  (imem_ren),
        .imem_addr (imem_addr),
        .imem_load (imem_load),
        .i_ready   (i_ready),
        .dmem_ren  (dmem_ren),
        .dmem_wen  (dmem_wen),
        .dmem_addr (dmem_addr),
        .dmem_store(dmem_store),
        .dmem_load (dmem_load),
        .d_ready   (d_ready),
        .bus_err   (bus_err),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_load  (ram_load),
        .ram_busy  (ram_busy)
    );

    typedef struct {
        logic          iren;
        logic          dren;
        logic          dwen;
        logic          drop_early;
        logic [AW-1:0] iaddr;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dstore;
        logic [DW-1:0] rload;
        int            busy_cycles;
    } vec_t;

    typedef struct {
        logic          is_data;
        logic          err;
        logic [DW-1:0] iload;
        logic [DW-1:0] dload;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    vec_t          vecs[10];
    int            checks = 0;
    int            fails  = 0;
    logic [DW-1:0] model_iload = '0;
    logic [DW-1:0] model_dload = '0;
    logic          last_data   = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every ready pulse is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_ready || d_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ready", {i_ready, d_ready}, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("ready_owner", {i_ready, d_ready}, mon_e.is_data ? 2'b01 : 2'b10);
                    checkOutput("bus_err", bus_err, mon_e.err);
                    checkOutput("imem_load", imem_load, mon_e.iload);
                    checkOutput("dmem_load", dmem_load, mon_e.dload);
                end
            end else if (bus_err) begin
                checkOutput("bus_err_stray", bus_err, 1'b0);
            end
        end
    end

    task automatic clearRequests();
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
    endtask

    // One transaction from IDLE: drives it, tracks strobes, drops requests on ready.
    task automatic applyStimulus(input vec_t v);
        exp_t          e;
        logic          is_data;
        logic          is_write;
        logic          err;
        logic [AW-1:0] exp_addr;
        int            exp_strobe;
        int            strobes;
        int            ready_at;
        bit            done;
        if (v.iren && (v.dren || v.dwen)) is_data = !last_data;
        else                              is_data = v.dren || v.dwen;
        last_data  = is_data;
        is_write   = is_data && v.dwen;
        err        = (v.busy_cycles >= TMO);
        exp_strobe = err ? TMO : v.busy_cycles + 1;
        exp_addr   = is_data ? v.daddr : v.iaddr;
        if (!is_write && !err) begin
            if (is_data) model_dload = v.rload;
            else         model_iload = v.rload;
        end
        e = '{is_data, err, model_iload, model_dload};
        sb.push_back(e);
        imem_ren   = v.iren;
        dmem_ren   = v.dren;
        dmem_wen   = v.dwen;
        imem_addr  = v.iaddr;
        dmem_addr  = v.daddr;
        dmem_store = v.dstore;
        ram_load   = v.rload;
        ram_busy   = 1'b0;
        strobes    = 0;
        ready_at   = -1;
        done       = 1'b0;
        for (int c = 0; c < TMO + 6 && !done; c++) begin
            @(negedge clk);
            if (ram_ren || ram_wen) begin
                strobes++;
                ram_busy = (strobes <= v.busy_cycles);
                checkOutput("ram_addr", ram_addr, exp_addr);
                if (strobes == 1) begin
                    checkOutput("ram_ren", ram_ren, !is_write);
                    checkOutput("ram_wen", ram_wen, is_write);
                    if (is_write) checkOutput("ram_store", ram_store, v.dstore);
                    if (v.drop_early) begin
                        clearRequests();
                        imem_addr = '1;
                        dmem_addr = '1;
                    end
                end
            end
            if (i_ready || d_ready) begin
                done     = 1'b1;
                ready_at = c;
                clearRequests();
                ram_busy = 1'b0;
            end
        end
        if (!done) checkOutput("ready_wait", 1'b0, 1'b1);
        checkOutput("strobe_cycles", strobes, exp_strobe);
        checkOutput("ready_latency", ready_at, exp_strobe);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 32'h0050_0093, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 3};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0200, 32'h0, 32'hA5A5_0001, 1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'h0, 32'h00A0_0113, 2};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0300, 32'h0, 32'hBAD0_BAD0, 4};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0018, 32'h0, 32'h0, 32'hFEED_0001, 6};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0400, 32'h0BAD_F00D, 32'h7777_7777, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0500, 32'h0, 32'h1357_9BDF, 2};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0600, 32'h0, 32'h0000_2468, 0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0000_0604, 32'h0, 32'h0000_CAFE, 1};

        rst        = 1'b1;
        clearRequests();
        imem_addr  = '0;
        dmem_addr  = '0;
        dmem_store = '0;
        ram_load   = 32'h5555_AAAA;
        ram_busy   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("rst_ram_ren", ram_ren, 1'b0);
        checkOutput("rst_ram_wen", ram_wen, 1'b0);
        checkOutput("rst_ram_addr", ram_addr, '0);
        checkOutput("rst_ram_store", ram_store, '0);
        checkOutput("rst_i_ready", i_ready, 1'b0);
        checkOutput("rst_d_ready", d_ready, 1'b0);
        checkOutput("rst_bus_err", bus_err, 1'b0);
        checkOutput("rst_imem_load", imem_load, '0);
        checkOutput("rst_dmem_load", dmem_load, '0);
        rst = 1'b0;
        @(negedge clk);

        // Held tie right after reset: data, fetch, data, back to back.
        begin
            logic [DW-1:0] loads[3];
            int            pulses;
            loads[0] = 32'hAAAA_0001;
            loads[1] = 32'hBBBB_0002;
            loads[2] = 32'hCCCC_0003;
            sb.push_back('{1'b1, 1'b0, model_iload, loads[0]});
            sb.push_back('{1'b0, 1'b0, loads[1], loads[0]});
            sb.push_back('{1'b1, 1'b0, loads[1], loads[2]});
            model_iload = loads[1];
            model_dload = loads[2];
            last_data   = 1'b1;
            imem_ren  = 1'b1;
            dmem_ren  = 1'b1;
            imem_addr = 32'h0000_0040;
            dmem_addr = 32'h0000_0800;
            ram_load  = loads[0];
            pulses    = 0;
            for (int c = 0; c < 20 && pulses < 3; c++) begin
                @(negedge clk);
                if (i_ready || d_ready) begin
                    pulses++;
                    if (pulses < 3) ram_load = loads[pulses];
                    else            clearRequests();
                end
            end
            checkOutput("tie_pulses", pulses, 3);
            clearRequests();
            @(negedge clk);
        end

        // Table of single transactions.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a read access.
        dmem_ren  = 1'b1;
        dmem_addr = 32'h0000_0700;
        ram_busy  = 1'b1;
        @(negedge clk);
        checkOutput("mid_ram_ren", ram_ren, 1'b1);
        #2 rst = 1'b1;
        #1 checkOutput("mid_rst_ram_ren", ram_ren, 1'b0);
        @(negedge clk);
        clearRequests();
        ram_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_iload = '0;
        model_dload = '0;
        last_data   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_ram_ren", ram_ren, 1'b0);
        checkOutput("post_rst_imem_load", imem_load, '0);
        checkOutput("post_rst_dmem_load", dmem_load, '0);
        checkOutput("post_rst_sb_empty", sb.size(), 0);

        applyStimulus('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'h0, 32'h0000_0001, 0});
        checkOutput("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
